// File: rtl/fft_pkg.sv
// Shared definitions for the radix-4 FFT datapath: digit width, read-side
// FSM state encoding and the base-4 digit-reversal helper.
package fft_pkg;

  // Width of one radix-4 digit in an index
  localparam int DIGIT_BITS = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  // Reverse the order of the base-4 digits in the low log2n bits of index.
  // Bits above log2n come back as zero.
  function automatic logic [31:0] digit_reverse(input logic [31:0] index,
                                                input int          log2n);
    logic [31:0] rev;
    int          ndig;
    rev  = '0;
    ndig = log2n / DIGIT_BITS;
    for (int d = 0; d < 16; d++) begin
      if (d < ndig) begin
        rev[(ndig-1-d)*DIGIT_BITS +: DIGIT_BITS] = index[d*DIGIT_BITS +: DIGIT_BITS];
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// Simple dual-port RAM holding both ping-pong banks. The address MSB is the
// bank select. The read port is registered; contents are never reset.
module fft_reorder_bank #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write in arrival order, read with one cycle of registered latency
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_digit_reorder.sv
// Output reorder stage for the radix-4 SDF FFT. Frames arrive in base-4
// digit-reversed order and leave in natural order through a ping-pong pair
// of N-entry banks. Defining FFT_REORDER_LAST_EN adds output_last, which
// marks the sample carrying natural index N-1.
module fft_digit_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             input_en,
  input  logic [WIDTH-1:0] input_real,
  input  logic [WIDTH-1:0] input_imag,
  output logic             output_en,
  output logic [WIDTH-1:0] output_real,
  output logic [WIDTH-1:0] output_imag
`ifdef FFT_REORDER_LAST_EN
  ,
  output logic             output_last
`endif
);

  localparam int ADDR_W = $clog2(N);

  if ((N < 16) || ((N & (N - 1)) != 0) || ((ADDR_W % DIGIT_BITS) != 0)) begin : g_bad_n
    $error("fft_digit_reorder: N must be a power of 4 and at least 16");
  end

  logic [ADDR_W-1:0]  wr_cnt;
  logic               wr_bank;
  logic [1:0]         bank_full;
  rd_state_e          rd_state;
  logic               rd_bank;
  logic [ADDR_W-1:0]  rd_cnt;
  logic               frame_done;
  logic               rd_en_p0;
  logic               rd_last_p0;
  logic [ADDR_W-1:0]  rd_rev_p0;
  logic [ADDR_W:0]    rd_addr_p0;
  logic [2*WIDTH-1:0] rd_data_p1;
  logic               vld_p1;

  assign frame_done = input_en && (wr_cnt == ADDR_W'(N - 1));
  assign rd_en_p0   = (rd_state == READ);
  assign rd_last_p0 = rd_en_p0 && (rd_cnt == ADDR_W'(N - 1));
  assign rd_rev_p0  = ADDR_W'(digit_reverse(32'(rd_cnt), ADDR_W));
  assign rd_addr_p0 = {rd_bank, rd_rev_p0};

  // Write counter and bank select: advance per accepted sample, flip bank at frame end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (input_en) begin
      if (frame_done) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt  <= wr_cnt + ADDR_W'(1);
      end
    end
  end

  // Full flags: set when a bank's last sample lands, cleared when its read-out ends
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank_full <= '0;
    end else begin
      if (rd_last_p0) begin
        bank_full[rd_bank] <= 1'b0;
      end
      if (frame_done) begin
        bank_full[wr_bank] <= 1'b1;
      end
    end
  end

  // Read FSM: start reading as soon as a frame completes, chain frames with no bubble
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_state <= IDLE;
      rd_bank  <= 1'b0;
      rd_cnt   <= '0;
    end else begin
      case (rd_state)
        IDLE: begin
          if (frame_done) begin
            rd_state <= READ;
            rd_bank  <= wr_bank;
            rd_cnt   <= '0;
          end
        end
        READ: begin
          rd_cnt <= rd_cnt + ADDR_W'(1);
          if (rd_cnt == ADDR_W'(N - 1)) begin
            // A frame finishing this very cycle always lands in the other bank
            if (bank_full[~rd_bank] || frame_done) begin
              rd_bank <= ~rd_bank;
              rd_cnt  <= '0;
            end else begin
              rd_state <= IDLE;
            end
          end
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

  fft_reorder_bank #(
    .DATA_W (2 * WIDTH),
    .ADDR_W (ADDR_W + 1)
  ) u_bank (
    .clock   (clock),
    .wr_en   (input_en),
    .wr_addr ({wr_bank, wr_cnt}),
    .wr_data ({input_real, input_imag}),
    .rd_addr (rd_addr_p0),
    .rd_data (rd_data_p1)
  );

  // ---- stage p1: RAM read data valid ----
  // Track which RAM read cycles carry a real sample
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en_p0;
    end
  end

  // ---- stage p2: registered output ----
  // Register the sample out; hold the last value while no sample is valid
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      output_en   <= 1'b0;
      output_real <= '0;
      output_imag <= '0;
    end else begin
      output_en <= vld_p1;
      if (vld_p1) begin
        {output_real, output_imag} <= rd_data_p1;
      end
    end
  end

`ifdef FFT_REORDER_LAST_EN
  logic last_p1;

  // Carry the end-of-frame marker alongside the read data to the output
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_p1     <= 1'b0;
      output_last <= 1'b0;
    end else begin
      last_p1     <= rd_last_p0;
      output_last <= last_p1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_digit_reorder.sv
// Self-checking bench for fft_digit_reorder: an N=16 instance and a default
// N=256 instance share clock and reset. Expected natural-order samples are
// queued when a frame is driven and compared as the DUT emits them.
module tb_fft_digit_reorder;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         en16, en256;
  logic [W-1:0] re16, im16, re256, im256;
  logic         o16_en, o256_en;
  logic [W-1:0] o16_re, o16_im, o256_re, o256_im;
`ifdef FFT_REORDER_LAST_EN
  logic         last16, last256;
`endif

  fft_digit_reorder #(.WIDTH(W), .N(16)) dut16 (
    .clock       (clock),
    .reset       (reset),
    .input_en    (en16),
    .input_real  (re16),
    .input_imag  (im16),
    .output_en   (o16_en),
    .output_real (o16_re),
    .output_imag (o16_im)
`ifdef FFT_REORDER_LAST_EN
    ,
    .output_last (last16)
`endif
  );

  fft_digit_reorder #(.WIDTH(W)) dut256 (
    .clock       (clock),
    .reset       (reset),
    .input_en    (en256),
    .input_real  (re256),
    .input_imag  (im256),
    .output_en   (o256_en),
    .output_real (o256_re),
    .output_imag (o256_im)
`ifdef FFT_REORDER_LAST_EN
    ,
    .output_last (last256)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    bit           last;
  } exp_t;

  typedef struct {
    int  base;
    bit  gaps;
    int  frames;
    int  exp_run;
    int  exp_lat;
  } case_t;

  typedef struct {
    int idx;
    int exp_re;
  } rev_vec_t;

  exp_t q16[$];
  exp_t q256[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int   run16 = 0, last_run16 = 0, rise16 = -1;
  int   run256 = 0, last_run256 = 0, rise256 = -1;
  bit   prev16 = 0, prev256 = 0;
  int   idx256 = 0;
  int   cap256 [256];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Base-4 digit reversal computed arithmetically
  function automatic int drev(input int idx, input int n);
    int r, v;
    r = 0;
    v = idx;
    for (int m = n; m > 1; m = m / 4) begin
      r = r * 4 + (v % 4);
      v = v / 4;
    end
    return r;
  endfunction

  // Output monitor for the N=16 instance
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (o16_en) begin
        if (q16.size() == 0) begin
          check("unexpected_out16", 1, 0);
        end else begin
          e = q16.pop_front();
          check("real16", o16_re, e.re);
          check("imag16", o16_im, e.im);
`ifdef FFT_REORDER_LAST_EN
          check("last16", last16, e.last);
`endif
        end
        if (!prev16 && rise16 < 0) rise16 = cyc;
        run16++;
      end else begin
        if (run16 != 0) last_run16 = run16;
        run16 = 0;
`ifdef FFT_REORDER_LAST_EN
        check("last16_idle", last16, 0);
`endif
      end
      prev16 = o16_en;
    end else begin
      prev16 = 1'b0;
      run16  = 0;
    end
  end

  // Output monitor for the N=256 instance
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (o256_en) begin
        if (q256.size() == 0) begin
          check("unexpected_out256", 1, 0);
        end else begin
          e = q256.pop_front();
          check("real256", o256_re, e.re);
          check("imag256", o256_im, e.im);
`ifdef FFT_REORDER_LAST_EN
          check("last256", last256, e.last);
`endif
        end
        if (idx256 < 256) cap256[idx256] = int'(o256_re);
        idx256++;
        if (!prev256 && rise256 < 0) rise256 = cyc;
        run256++;
      end else begin
        if (run256 != 0) last_run256 = run256;
        run256 = 0;
      end
      prev256 = o256_en;
    end else begin
      prev256 = 1'b0;
      run256  = 0;
    end
  end

  // Drive frames into the N=16 instance in digit-reversed order
  task automatic drive16(input int base, input bit gaps, input int frames, output int f1end);
    exp_t e;
    f1end = 0;
    for (int f = 0; f < frames; f++) begin
      for (int p = 0; p < 16; p++) begin
        if (gaps) begin
          en16 = 1'b0;
          @(posedge clock); #1;
        end
        en16 = 1'b1;
        re16 = W'(base + 16 * f + drev(p, 16));
        im16 = W'(100 + base + 16 * f + drev(p, 16));
        @(posedge clock); #1;
      end
      if (f == 0) f1end = cyc;
      for (int k = 0; k < 16; k++) begin
        e.re   = W'(base + 16 * f + k);
        e.im   = W'(100 + base + 16 * f + k);
        e.last = (k == 15);
        q16.push_back(e);
      end
    end
    en16 = 1'b0;
  endtask

  task automatic wait_idle16();
    int budget = 0;
    while ((q16.size() != 0 || o16_en) && budget < 300) begin
      @(posedge clock); #1;
      budget++;
    end
    check("idle16_timeout", budget >= 300, 0);
    @(posedge clock); #1;
  endtask

  task automatic wait_idle256();
    int budget = 0;
    while ((q256.size() != 0 || o256_en) && budget < 1000) begin
      @(posedge clock); #1;
      budget++;
    end
    check("idle256_timeout", budget >= 1000, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    case_t    cases [4];
    rev_vec_t rv [6];
    int       f1end;
    exp_t     e;

    cases[0] = '{base: 0,   gaps: 1'b0, frames: 1, exp_run: 16, exp_lat: 2};
    cases[1] = '{base: 0,   gaps: 1'b1, frames: 1, exp_run: 16, exp_lat: 2};
    cases[2] = '{base: 0,   gaps: 1'b0, frames: 3, exp_run: 48, exp_lat: 2};
    cases[3] = '{base: 400, gaps: 1'b0, frames: 2, exp_run: 32, exp_lat: 2};

    rv[0] = '{idx: 0,   exp_re: 0};
    rv[1] = '{idx: 1,   exp_re: 64};
    rv[2] = '{idx: 2,   exp_re: 128};
    rv[3] = '{idx: 3,   exp_re: 192};
    rv[4] = '{idx: 4,   exp_re: 16};
    rv[5] = '{idx: 255, exp_re: 255};

    reset = 1'b0;
    en16  = 1'b0; re16  = '0; im16  = '0;
    en256 = 1'b0; re256 = '0; im256 = '0;
    #2;
    check("rst_en16",   o16_en,  0);
    check("rst_real16", o16_re,  0);
    check("rst_imag16", o16_im,  0);
    check("rst_en256",  o256_en, 0);
    check("rst_real256", o256_re, 0);
`ifdef FFT_REORDER_LAST_EN
    check("rst_last16", last16, 0);
`endif
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Table of frame scenarios on the N=16 instance
    for (int i = 0; i < 4; i++) begin
      rise16     = -1;
      last_run16 = 0;
      drive16(cases[i].base, cases[i].gaps, cases[i].frames, f1end);
      wait_idle16();
      check($sformatf("lat16_case%0d", i), 64'(rise16 - f1end), 64'(cases[i].exp_lat));
      check($sformatf("run16_case%0d", i), 64'(last_run16), 64'(cases[i].exp_run));
      check($sformatf("drain16_case%0d", i), 64'(q16.size()), 0);
      check($sformatf("hold_real16_case%0d", i), o16_re,
            W'(cases[i].base + 16 * cases[i].frames - 1));
    end

    // Partial frame of 10 samples discarded by reset
    for (int p = 0; p < 10; p++) begin
      en16 = 1'b1;
      re16 = W'(900 + drev(p, 16));
      im16 = W'(1000 + drev(p, 16));
      @(posedge clock); #1;
    end
    en16  = 1'b0;
    reset = 1'b0;
    #1;
    check("partial_rst_en16", o16_en, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    check("partial_idle_en16", o16_en, 0);
    rise16 = -1; last_run16 = 0;
    drive16(200, 1'b0, 1, f1end);
    wait_idle16();
    check("after_partial_lat16", 64'(rise16 - f1end), 2);
    check("after_partial_run16", 64'(last_run16), 16);

    // Reset asserted while a frame is streaming out drops output_en at once
    drive16(600, 1'b0, 1, f1end);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_en16",   o16_en, 0);
    check("async_rst_real16", o16_re, 0);
    check("async_rst_imag16", o16_im, 0);
    q16.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    check("async_idle_en16", o16_en, 0);
    rise16 = -1; last_run16 = 0;
    drive16(700, 1'b0, 1, f1end);
    wait_idle16();
    check("after_async_lat16", 64'(rise16 - f1end), 2);
    check("after_async_run16", 64'(last_run16), 16);

    // N=256: real=k at input position k, natural index m must carry digit_rev(m)
    rise256 = -1; last_run256 = 0; idx256 = 0;
    for (int k = 0; k < 256; k++) begin
      en256 = 1'b1;
      re256 = W'(k);
      im256 = W'(5000 + k);
      @(posedge clock); #1;
    end
    en256 = 1'b0;
    f1end = cyc;
    for (int m = 0; m < 256; m++) begin
      e.re   = W'(drev(m, 256));
      e.im   = W'(5000 + drev(m, 256));
      e.last = (m == 255);
      q256.push_back(e);
    end
    wait_idle256();
    check("lat256", 64'(rise256 - f1end), 2);
    check("run256", 64'(last_run256), 256);
    check("count256", 64'(idx256), 256);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rev256_idx%0d", rv[i].idx), 64'(cap256[rv[i].idx]), 64'(rv[i].exp_re));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
